// File: rtl/dtcm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dtcm_ctrl_pkg
//  Description : Shared constants and types for the DTCM controller and its
//                response buffer (also usable by the ITCM controller).
//  Revision    : 1.0 - initial release
// ============================================================================
package dtcm_ctrl_pkg;

    // Byte address width of the data TCM
    localparam int C_DTCM_ADDR_WIDTH = 16;
    // Data width; one RAM word is one XLEN word
    localparam int C_XLEN            = 32;
    // RAM word address width (byte address minus the in-word offset)
    localparam int C_DTCM_RAM_AW     = C_DTCM_ADDR_WIDTH - 2;
    // Default number of response buffer entries
    localparam int C_RSP_DEPTH       = 2;

    typedef logic [C_XLEN-1:0] xword_t;

endpackage : dtcm_ctrl_pkg
`default_nettype wire

// File: rtl/dtcm_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dtcm_rsp_fifo
//  Description : Synchronous FIFO with push/pop/occupancy count. Holds RAM
//                responses the LSU has not yet taken. DEPTH is a power of 2
//                so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module dtcm_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int              PW        = $clog2(DEPTH);
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   C_PTR_ONE = PW'(1);
    localparam logic [CW-1:0]   C_CNT_ONE = CW'(1);
    localparam logic [CW-1:0]   C_DEPTH   = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_do_push = push & ~w_full;
    assign w_do_pop  = pop & ~w_empty;

    // Storage array write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A push into a full buffer would drop a response
    assert property (@(posedge clk) disable iff (!rst_n) !(push && w_full))
        else $error("dtcm_rsp_fifo: push while full");

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = w_empty;

endmodule : dtcm_rsp_fifo
`default_nettype wire

// File: rtl/dtcm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dtcm_ctrl
//  Description : Data-TCM controller between the LSU and a single-port,
//                byte-maskable synchronous SRAM (1-cycle read latency).
//                One response per command, strictly in order; a small
//                response buffer absorbs LSU back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module dtcm_ctrl
    import dtcm_ctrl_pkg::*;
#(
    parameter int DTCM_ADDR_WIDTH = C_DTCM_ADDR_WIDTH,
    parameter int XLEN            = C_XLEN,
    parameter int RSP_DEPTH       = C_RSP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lsu2dtcm_cmd_valid,
    output logic                         lsu2dtcm_cmd_ready,
    input  logic                         lsu2dtcm_cmd_read,
    input  logic [DTCM_ADDR_WIDTH-1:0]   lsu2dtcm_cmd_addr,
    input  logic [XLEN-1:0]              lsu2dtcm_cmd_wdata,
    input  logic [XLEN/8-1:0]            lsu2dtcm_cmd_wmask,
    output logic                         lsu2dtcm_rsp_valid,
    input  logic                         lsu2dtcm_rsp_ready,
    output logic [XLEN-1:0]              lsu2dtcm_rsp_rdata,
    output logic                         dtcm_ram_cs,
    output logic                         dtcm_ram_we,
    output logic [DTCM_ADDR_WIDTH-3:0]   dtcm_ram_addr,
    output logic [XLEN/8-1:0]            dtcm_ram_wem,
    output logic [XLEN-1:0]              dtcm_ram_din,
    input  logic [XLEN-1:0]              dtcm_ram_dout
);

    localparam int            CW      = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(RSP_DEPTH);

    logic            r_inflight;
    logic            r_inflight_read;

    logic            w_accept;
    logic [CW-1:0]   w_occupancy;
    logic [XLEN-1:0] w_resp_data;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_fifo_dout;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic            w_unused_addr_lsb;

    // Reserve a buffer slot for every accepted command, including the one
    // whose RAM access is still in flight; depends on registered state only.
    assign w_occupancy        = w_fifo_count + {{(CW-1){1'b0}}, r_inflight};
    assign lsu2dtcm_cmd_ready = (w_occupancy < C_DEPTH);
    assign w_accept           = lsu2dtcm_cmd_valid & lsu2dtcm_cmd_ready;

    // RAM is driven straight from the command in the accepting cycle
    assign dtcm_ram_cs   = w_accept;
    assign dtcm_ram_we   = w_accept & ~lsu2dtcm_cmd_read;
    assign dtcm_ram_addr = lsu2dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2];
    assign dtcm_ram_wem  = lsu2dtcm_cmd_wmask;
    assign dtcm_ram_din  = lsu2dtcm_cmd_wdata;

    // Byte offset is irrelevant to a word-wide RAM
    assign w_unused_addr_lsb = ^lsu2dtcm_cmd_addr[1:0];

    // Track the access issued this cycle so its data is captured next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_read <= 1'b0;
        end else begin
            r_inflight      <= w_accept;
            r_inflight_read <= w_accept & lsu2dtcm_cmd_read;
        end
    end

    // Stores answer with zero data
    assign w_resp_data = r_inflight_read ? dtcm_ram_dout : '0;

    // Buffered responses are older than the in-flight one, so they go first;
    // with an empty buffer and a ready LSU the RAM data skips the buffer.
    assign w_bypass = w_fifo_empty & r_inflight & lsu2dtcm_rsp_ready;
    assign w_push   = r_inflight & ~w_bypass;
    assign w_pop    = ~w_fifo_empty & lsu2dtcm_rsp_ready;

    assign lsu2dtcm_rsp_valid = ~w_fifo_empty | r_inflight;
    assign lsu2dtcm_rsp_rdata = w_fifo_empty ? w_resp_data : w_fifo_dout;

    dtcm_rsp_fifo #(
        .WIDTH (XLEN),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_resp_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty)
    );

endmodule : dtcm_ctrl
`default_nettype wire

// File: tb/tb_dtcm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dtcm_ctrl
//  Description : Directed and randomised bench for dtcm_ctrl with a behavioural
//                SRAM and an in-order reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dtcm_ctrl;

    localparam int AW  = 16;
    localparam int XL  = 32;
    localparam int RAW = AW - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_read = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [XL-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [XL-1:0] rsp_rdata;
    logic          ram_cs;
    logic          ram_we;
    logic [RAW-1:0] ram_addr;
    logic [3:0]    ram_wem;
    logic [XL-1:0] ram_din;
    logic [XL-1:0] ram_dout = '0;

    logic [XL-1:0] ram [0:(1<<RAW)-1] = '{default: '0};
    logic [XL-1:0] mdl [0:(1<<RAW)-1] = '{default: '0};
    logic [RAW-1:0] mon_wa;

    logic [XL-1:0] rx_q [$];
    logic [XL-1:0] exp_q [$];

    logic [AW-1:0] bp_addr [4] = '{16'h0010, 16'h0020, 16'h0010, 16'h0020};
    logic [XL-1:0] bp_exp  [4] = '{32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dtcm_ctrl #(
        .DTCM_ADDR_WIDTH (AW),
        .XLEN            (XL),
        .RSP_DEPTH       (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lsu2dtcm_cmd_valid (cmd_valid),
        .lsu2dtcm_cmd_ready (cmd_ready),
        .lsu2dtcm_cmd_read  (cmd_read),
        .lsu2dtcm_cmd_addr  (cmd_addr),
        .lsu2dtcm_cmd_wdata (cmd_wdata),
        .lsu2dtcm_cmd_wmask (cmd_wmask),
        .lsu2dtcm_rsp_valid (rsp_valid),
        .lsu2dtcm_rsp_ready (rsp_ready),
        .lsu2dtcm_rsp_rdata (rsp_rdata),
        .dtcm_ram_cs        (ram_cs),
        .dtcm_ram_we        (ram_we),
        .dtcm_ram_addr      (ram_addr),
        .dtcm_ram_wem       (ram_wem),
        .dtcm_ram_din       (ram_din),
        .dtcm_ram_dout      (ram_dout)
    );

    // Behavioural single-port SRAM, byte-maskable, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram[ram_addr];
            end
        end
    end

    // Handshake monitor: inputs are stable from posedge+1 to the next posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) rx_q.push_back(rsp_rdata);
            if (cmd_valid && cmd_ready) begin
                mon_wa = cmd_addr[AW-1:2];
                if (cmd_read) begin
                    exp_q.push_back(mdl[mon_wa]);
                end else begin
                    exp_q.push_back('0);
                    for (int b = 0; b < 4; b++)
                        if (cmd_wmask[b]) mdl[mon_wa][8*b +: 8] = cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    function automatic logic [XL-1:0] pat(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        exp_q.delete();
    endtask

    // Present one command and hold it until accepted (bounded)
    task automatic send_cmd(input logic rd, input logic [AW-1:0] a,
                            input logic [XL-1:0] wd, input logic [3:0] wm);
        int n;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = wm;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_cmd_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready); end
        checks++;
        if (ram_cs !== 1'b0) begin errors++; $display("FAIL reset_ram_cs: got %0b required 0", ram_cs); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = 16'h0010;
        cmd_wdata = 32'hDEADBEEF;
        cmd_wmask = 4'hF;
        @(negedge clk);
        checks++;
        if ({cmd_ready, ram_cs, ram_we} !== 3'b111) begin
            errors++; $display("FAIL store_ram_ctrl: ready/cs/we=%b required 111", {cmd_ready, ram_cs, ram_we});
        end
        checks++;
        if (ram_addr !== 14'h0004) begin errors++; $display("FAIL store_ram_addr: got %h required 0004", ram_addr); end
        checks++;
        if (ram_wem !== 4'hF || ram_din !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_ram_data: wem=%h din=%h required F DEADBEEF", ram_wem, ram_din);
        end
        @(posedge clk);
        #1;
        cmd_read  = 1'b1;
        cmd_wdata = '0;
        cmd_wmask = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL store_rsp: valid=%0b rdata=%h required 1 00000000", rsp_valid, rsp_rdata);
        end
        checks++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 14'h0004) begin
            errors++; $display("FAIL load_ram_ctrl: cs=%0b we=%0b addr=%h required 1 0 0004", ram_cs, ram_we, ram_addr);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_rsp: valid=%0b rdata=%h required 1 DEADBEEF", rsp_valid, rsp_rdata);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_rsp_done: valid=%0b required 0", rsp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_byte_mask();
        clear_q();
        rsp_ready = 1'b1;
        send_cmd(1'b0, 16'h0020, 32'h11223344, 4'hF);
        send_cmd(1'b0, 16'h0020, 32'hAABBCCDD, 4'b0101);
        send_cmd(1'b1, 16'h0020, 32'h0, 4'h0);
        cyc(3);
        checks++;
        if (rx_q.size() != 3) begin
            errors++; $display("FAIL mask_rsp_count: got %0d required 3", rx_q.size());
        end else begin
            checks++;
            if (rx_q[2] !== 32'h11BB33DD) begin errors++; $display("FAIL mask_load: got %h required 11BB33DD", rx_q[2]); end
            checks++;
            if (rx_q[1] !== 32'h0) begin errors++; $display("FAIL mask_store_rsp: got %h required 00000000", rx_q[1]); end
        end
    endtask

    task automatic test_back_pressure();
        int idx;
        int guard;
        logic got;
        clear_q();
        rsp_ready = 1'b0;
        idx = 0;
        repeat (6) begin
            cmd_valid = 1'b1;
            cmd_read  = 1'b1;
            cmd_addr  = bp_addr[idx];
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
            #1;
            if (got) idx++;
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d required 2", idx); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready: got %0b required 0", cmd_ready); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bp_head: valid=%0b rdata=%h required 1 DEADBEEF", rsp_valid, rsp_rdata);
        end
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL bp_no_rsp: got %0d required 0", rx_q.size()); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            cmd_addr = bp_addr[idx];
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk);
            #1;
            if (got) idx++;
            guard++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (idx != 4) begin errors++; $display("FAIL bp_resume: accepted %0d required 4", idx); end
        cyc(4);
        checks++;
        if (rx_q.size() != 4) begin
            errors++; $display("FAIL bp_rsp_count: got %0d required 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[i] !== bp_exp[i]) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h required %h", i, rx_q[i], bp_exp[i]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        int stalls;
        rsp_ready = 1'b1;
        stalls = 0;
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_wmask = 4'hF;
        for (int i = 0; i < 16; i++) begin
            cmd_addr  = 16'h0100 + 16'(4*i);
            cmd_wdata = pat(i);
            @(negedge clk);
            if (!cmd_ready) stalls++;
            @(posedge clk);
            #1;
        end
        cmd_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_addr = 16'h0100 + 16'(4*i);
            @(negedge clk);
            if (!cmd_ready) stalls++;
            if (i > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== pat(i-1)) begin
                    errors++; $display("FAIL stream_rsp[%0d]: valid=%0b rdata=%h required 1 %h", i-1, rsp_valid, rsp_rdata, pat(i-1));
                end
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat(15)) begin
            errors++; $display("FAIL stream_rsp[15]: valid=%0b rdata=%h required 1 %h", rsp_valid, rsp_rdata, pat(15));
        end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL stream_stalls: got %0d required 0", stalls); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int guard;
        int nfail;
        logic got;
        clear_q();
        for (int n = 0; n < 1000; n++) begin
            cmd_valid = 1'b1;
            cmd_read  = 1'($urandom_range(0, 1));
            cmd_addr  = 16'h0200 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
            cmd_wdata = $urandom;
            cmd_wmask = 4'($urandom_range(0, 15));
            rsp_ready = 1'($urandom_range(0, 1));
            guard = 0;
            do begin
                @(negedge clk);
                got = cmd_ready;
                @(posedge clk);
                #1;
                rsp_ready = 1'($urandom_range(0, 1));
                guard++;
            end while (!got && guard < 100);
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL rand_accept_timeout: cmd %0d not accepted, required acceptance", n);
                break;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc(5);
        checks++;
        if (rx_q.size() != 1000 || exp_q.size() != 1000) begin
            errors++; $display("FAIL rand_rsp_count: got %0d responses for %0d commands, required 1000", rx_q.size(), exp_q.size());
        end
        nfail = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                nfail++;
                $display("FAIL rand_rsp[%0d]: got %h required %h", i, rx_q[i], exp_q[i]);
                if (nfail >= 10) break;
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        rsp_ready = 1'b0;
        send_cmd(1'b1, 16'h0010, 32'h0, 4'h0);
        send_cmd(1'b1, 16'h0020, 32'h0, 4'h0);
        cyc(1);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_full: ready=%0b valid=%0b required 0 1", cmd_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid: got %0b required 0", rsp_valid); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %0b required 1", cmd_ready); end
        checks++;
        if (ram_cs !== 1'b0) begin errors++; $display("FAIL rstmid_ram_cs: got %0b required 0", ram_cs); end
        @(posedge clk);
        #1;
        clear_q();
        rsp_ready = 1'b1;
        cyc(4);
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_stale: got %0d responses required 0", rx_q.size()); end
        send_cmd(1'b1, 16'h0010, 32'h0, 4'h0);
        cyc(2);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rstmid_after: count=%0d first=%h required 1 DEADBEEF",
                               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_store_load();
        test_byte_mask();
        test_back_pressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dtcm_ctrl
`default_nettype wire
